order_checker: RTL and testbench

Round controller that sits directly downstream of the menu randomiser. On `start` it snapshots the three 2-bit dish IDs, then checks the player's dish selections against them in order. It enforces a per-round countdown and a mistake limit, and keeps a running score. Its status outputs feed the OLED drawing logic next to `draw_menu`.

---
 rtl/order_pkg.sv | 17 +
 rtl/second_ticker.sv | 31 +++
 rtl/order_checker.sv | 128 ++++++++++++
 tb/tb_order_checker.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/order_pkg.sv
// Shared types and widths for the order_checker round controller.
package order_pkg;

    localparam int ITEM_W  = 2;
    localparam int SLOT_W  = 2;
    localparam int SCORE_W = 8;
    localparam int TIME_W  = 6;
    localparam int MIS_W   = 2;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        WON,
        LOST
    } state_t;

endpackage

// File: rtl/second_ticker.sv
// Prescaler that emits a one-cycle tick every TICKS_PER_SEC cycles while enabled.
// The count is held at zero whenever enable is low.
module second_ticker #(
    parameter int TICKS_PER_SEC = 100_000_000
) (
    input  logic basys_clk,
    input  logic reset,
    input  logic enable,
    output logic tick
);

    localparam int CNT_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

    logic [CNT_W-1:0] count;
    logic             wrap;

    assign wrap = (count == CNT_W'(TICKS_PER_SEC - 1));
    assign tick = enable && wrap;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge basys_clk) begin
        if (reset || !enable) begin
            count <= '0;
        end else if (wrap) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/order_checker.sv
// Round controller: snapshots three target dishes on start, checks submits in order,
// and tracks countdown, mistakes and a saturating win score.
module order_checker
    import order_pkg::*;
#(
    parameter int TICKS_PER_SEC = 100_000_000,
    parameter int TIME_LIMIT_S  = 30,
    parameter int MAX_MISTAKES  = 3
) (
    input  logic                basys_clk,
    input  logic                reset,
    input  logic                start,
    input  logic [ITEM_W-1:0]   item_1,
    input  logic [ITEM_W-1:0]   item_2,
    input  logic [ITEM_W-1:0]   item_3,
    input  logic [ITEM_W-1:0]   sel,
    input  logic                submit,
    output logic [SLOT_W-1:0]   slot,
    output logic                active,
    output logic                won,
    output logic                lost,
    output logic [TIME_W-1:0]   time_left,
    output logic [MIS_W-1:0]    mistakes,
    output logic [SCORE_W-1:0]  score
);

    state_t               state, state_next;
    logic [2:0][ITEM_W-1:0] target;
    logic [ITEM_W-1:0]    expected;
    logic [SLOT_W-1:0]    slot_next;
    logic [TIME_W-1:0]    time_left_next;
    logic [MIS_W-1:0]     mistakes_next, mistakes_inc;
    logic [SCORE_W-1:0]   score_next;
    logic                 load_targets;
    logic                 tick;

    second_ticker #(
        .TICKS_PER_SEC(TICKS_PER_SEC)
    ) u_second_ticker (
        .basys_clk(basys_clk),
        .reset    (reset),
        .enable   (state == ACTIVE),
        .tick     (tick)
    );

    always_comb begin
        case (slot)
            2'd0:    expected = target[0];
            2'd1:    expected = target[1];
            default: expected = target[2];
        endcase
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_next     = state;
        slot_next      = slot;
        time_left_next = time_left;
        mistakes_next  = mistakes;
        score_next     = score;
        load_targets   = 1'b0;
        mistakes_inc   = mistakes + MIS_W'(1);

        case (state)
            ACTIVE: begin
                if (tick) begin
                    if (time_left != '0) time_left_next = time_left - TIME_W'(1);
                    if (time_left <= TIME_W'(1)) state_next = LOST;
                end
                if (submit) begin
                    if (sel == expected) begin
                        if (slot == SLOT_W'(2)) begin
                            // A winning submit overrides a same-cycle timeout and freezes the clock.
                            slot_next      = SLOT_W'(3);
                            state_next     = WON;
                            time_left_next = time_left;
                            if (score != '1) score_next = score + SCORE_W'(1);
                        end else begin
                            slot_next = slot + SLOT_W'(1);
                        end
                    end else begin
                        mistakes_next = mistakes_inc;
                        if (mistakes_inc == MIS_W'(MAX_MISTAKES)) state_next = LOST;
                    end
                end
            end
            default: begin
                if (start) begin
                    load_targets   = 1'b1;
                    slot_next      = '0;
                    mistakes_next  = '0;
                    time_left_next = TIME_W'(TIME_LIMIT_S);
                    state_next     = ACTIVE;
                end
            end
        endcase
    end

    always_ff @(posedge basys_clk) begin
        if (reset) begin
            state     <= IDLE;
            slot      <= '0;
            time_left <= '0;
            mistakes  <= '0;
            score     <= '0;
        end else begin
            state     <= state_next;
            slot      <= slot_next;
            time_left <= time_left_next;
            mistakes  <= mistakes_next;
            score     <= score_next;
        end
    end

    // NOTE: target storage has no reset; it is always loaded by start before it is compared.
    always_ff @(posedge basys_clk) begin
        if (load_targets) begin
            target[0] <= item_1;
            target[1] <= item_2;
            target[2] <= item_3;
        end
    end

    assign active = (state == ACTIVE);
    assign won    = (state == WON);
    assign lost   = (state == LOST);

endmodule

// File: tb/tb_order_checker.sv
// Scoreboard bench for order_checker with TICKS_PER_SEC=4, TIME_LIMIT_S=3, MAX_MISTAKES=3.
module tb_order_checker;

    typedef struct packed {
        logic [1:0] slot;
        logic       active;
        logic       won;
        logic       lost;
        logic [5:0] tl;
        logic [1:0] mis;
        logic [7:0] score;
    } snap_t;

    typedef struct {
        int    cyc;
        string name;
        snap_t val;
    } exp_t;

    logic       basys_clk;
    logic       reset;
    logic       start;
    logic [1:0] item_1, item_2, item_3;
    logic [1:0] sel;
    logic       submit;
    logic [1:0] slot;
    logic       active, won, lost;
    logic [5:0] time_left;
    logic [1:0] mistakes;
    logic [7:0] score;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   exp_score;

    order_checker #(
        .TICKS_PER_SEC(4),
        .TIME_LIMIT_S (3),
        .MAX_MISTAKES (3)
    ) dut (
        .basys_clk(basys_clk),
        .reset    (reset),
        .start    (start),
        .item_1   (item_1),
        .item_2   (item_2),
        .item_3   (item_3),
        .sel      (sel),
        .submit   (submit),
        .slot     (slot),
        .active   (active),
        .won      (won),
        .lost     (lost),
        .time_left(time_left),
        .mistakes (mistakes),
        .score    (score)
    );

    initial basys_clk = 1'b0;
    always #5 basys_clk = ~basys_clk;

    always @(posedge basys_clk) cyc <= cyc + 1;

    task automatic step();
        @(posedge basys_clk);
        #1;
    endtask

    task automatic exp_at(input int dc, input string name, input logic [1:0] s,
                          input logic a, input logic w, input logic l,
                          input logic [5:0] t, input logic [1:0] m, input logic [7:0] sc);
        exp_t e;
        e.cyc  = cyc + dc;
        e.name = name;
        e.val  = '{slot: s, active: a, won: w, lost: l, tl: t, mis: m, score: sc};
        sb.push_back(e);
    endtask

    // Monitor: compares every expectation that falls due in the current cycle.
    always @(negedge basys_clk) begin
        exp_t  e;
        snap_t got;
        got = '{slot: slot, active: active, won: won, lost: lost,
                tl: time_left, mis: mistakes, score: score};
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            checks++;
            if (e.cyc != cyc) begin
                errors++;
                $display("FAIL %s: due at cycle %0d but not sampled (now %0d)", e.name, e.cyc, cyc);
            end else if (got !== e.val) begin
                errors++;
                $display("FAIL %s @%0d: got slot=%0d act=%0d won=%0d lost=%0d tl=%0d mis=%0d score=%0d, expected slot=%0d act=%0d won=%0d lost=%0d tl=%0d mis=%0d score=%0d",
                         e.name, cyc, got.slot, got.active, got.won, got.lost, got.tl, got.mis, got.score,
                         e.val.slot, e.val.active, e.val.won, e.val.lost, e.val.tl, e.val.mis, e.val.score);
            end
        end
    end

    // Start a round with all targets 0 and win it in three consecutive submits.
    task automatic quick_win(input string name);
        item_1 = 2'd0; item_2 = 2'd0; item_3 = 2'd0;
        start = 1'b1;
        exp_score = (exp_score == 255) ? 255 : exp_score + 1;
        exp_at(4, name, 2'd3, 1'b0, 1'b1, 1'b0, 6'd3, 2'd0, 8'(exp_score));
        step();
        start = 1'b0; submit = 1'b1; sel = 2'd0;
        step(); step(); step();
        submit = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; submit = 1'b0; sel = 2'd0;
        item_1 = 2'd0; item_2 = 2'd0; item_3 = 2'd0;
        step(); step();
        exp_at(1, "reset_init", 2'd0, 0, 0, 0, 6'd0, 2'd0, 8'd0);
        step();
        reset = 1'b0;

        // Submit while idle is ignored.
        submit = 1'b1; sel = 2'd0;
        exp_at(1, "idle_submit", 2'd0, 0, 0, 0, 6'd0, 2'd0, 8'd0);
        step();
        submit = 1'b0;
        step();

        // Clean win.
        item_1 = 2'd1; item_2 = 2'd2; item_3 = 2'd3; start = 1'b1;
        exp_at(1, "win_start", 2'd0, 1, 0, 0, 6'd3, 2'd0, 8'd0);
        exp_at(2, "win_slot1", 2'd1, 1, 0, 0, 6'd3, 2'd0, 8'd0);
        exp_at(3, "win_slot2", 2'd2, 1, 0, 0, 6'd3, 2'd0, 8'd0);
        exp_at(4, "win_done",  2'd3, 0, 1, 0, 6'd3, 2'd0, 8'd1);
        exp_at(5, "win_hold",  2'd3, 0, 1, 0, 6'd3, 2'd0, 8'd1);
        step();
        start = 1'b0; submit = 1'b1; sel = 2'd1;
        step(); sel = 2'd2;
        step(); sel = 2'd3;
        step(); submit = 1'b0;
        step();

        // Mistakes to loss.
        item_1 = 2'd0; item_2 = 2'd0; item_3 = 2'd0; start = 1'b1;
        exp_at(1, "mis_start", 2'd0, 1, 0, 0, 6'd3, 2'd0, 8'd1);
        exp_at(2, "mis_1",     2'd0, 1, 0, 0, 6'd3, 2'd1, 8'd1);
        exp_at(3, "mis_2",     2'd0, 1, 0, 0, 6'd3, 2'd2, 8'd1);
        exp_at(4, "mis_lost",  2'd0, 0, 0, 1, 6'd3, 2'd3, 8'd1);
        step();
        start = 1'b0; submit = 1'b1; sel = 2'd2;
        step(); step(); step();
        submit = 1'b0;
        step();
        submit = 1'b1; sel = 2'd0;
        exp_at(1, "lost_submit", 2'd0, 0, 0, 1, 6'd3, 2'd3, 8'd1);
        step();
        submit = 1'b0;

        // Timeout with no submits.
        start = 1'b1;
        exp_at(1,  "to_3",    2'd0, 1, 0, 0, 6'd3, 2'd0, 8'd1);
        exp_at(5,  "to_2",    2'd0, 1, 0, 0, 6'd2, 2'd0, 8'd1);
        exp_at(9,  "to_1",    2'd0, 1, 0, 0, 6'd1, 2'd0, 8'd1);
        exp_at(12, "to_1end", 2'd0, 1, 0, 0, 6'd1, 2'd0, 8'd1);
        exp_at(13, "to_0",    2'd0, 0, 0, 1, 6'd0, 2'd0, 8'd1);
        exp_at(14, "to_hold", 2'd0, 0, 0, 1, 6'd0, 2'd0, 8'd1);
        step();
        start = 1'b0;
        repeat (14) step();

        // Snapshot: items change and a start is pulsed mid-round.
        item_1 = 2'd1; item_2 = 2'd1; item_3 = 2'd1; start = 1'b1;
        exp_at(1, "snap_start",    2'd0, 1, 0, 0, 6'd3, 2'd0, 8'd1);
        exp_at(2, "start_ignored", 2'd0, 1, 0, 0, 6'd3, 2'd0, 8'd1);
        exp_at(3, "snap_s1",       2'd1, 1, 0, 0, 6'd3, 2'd0, 8'd1);
        exp_at(4, "snap_s2",       2'd2, 1, 0, 0, 6'd3, 2'd0, 8'd1);
        exp_at(5, "snap_won",      2'd3, 0, 1, 0, 6'd3, 2'd0, 8'd2);
        step();
        item_1 = 2'd2; item_2 = 2'd2; item_3 = 2'd2; start = 1'b1;
        step();
        start = 1'b0; submit = 1'b1; sel = 2'd1;
        step(); step(); step();
        submit = 1'b0;
        step();

        // Final correct submit on the tick that takes time_left 1 -> 0.
        item_1 = 2'd0; item_2 = 2'd1; item_3 = 2'd2; start = 1'b1;
        exp_at(1,  "sim_start", 2'd0, 1, 0, 0, 6'd3, 2'd0, 8'd2);
        exp_at(3,  "sim_slot2", 2'd2, 1, 0, 0, 6'd3, 2'd0, 8'd2);
        exp_at(9,  "sim_t1",    2'd2, 1, 0, 0, 6'd1, 2'd0, 8'd2);
        exp_at(13, "sim_won",   2'd3, 0, 1, 0, 6'd1, 2'd0, 8'd3);
        step();
        start = 1'b0; submit = 1'b1; sel = 2'd0;
        step(); sel = 2'd1;
        step(); submit = 1'b0;
        repeat (9) step();
        submit = 1'b1; sel = 2'd2;
        step();
        submit = 1'b0;
        step();

        // Third mistake on the timeout tick: lost with mistakes still counted.
        item_1 = 2'd0; item_2 = 2'd0; item_3 = 2'd0; start = 1'b1;
        exp_at(1,  "mt_start", 2'd0, 1, 0, 0, 6'd3, 2'd0, 8'd3);
        exp_at(12, "mt_mis2",  2'd0, 1, 0, 0, 6'd1, 2'd2, 8'd3);
        exp_at(13, "mt_lost",  2'd0, 0, 0, 1, 6'd0, 2'd3, 8'd3);
        step();
        start = 1'b0;
        repeat (9) step();
        submit = 1'b1; sel = 2'd3;
        step(); step(); step();
        submit = 1'b0;
        step();

        // Two more wins, then reset in mid-round at score 5, slot 2.
        exp_score = 3;
        quick_win("pre_win");
        quick_win("pre_win");
        item_1 = 2'd0; item_2 = 2'd1; item_3 = 2'd2; start = 1'b1;
        exp_at(3, "rst_pre",   2'd2, 1, 0, 0, 6'd3, 2'd0, 8'd5);
        exp_at(4, "rst_mid",   2'd0, 0, 0, 0, 6'd0, 2'd0, 8'd0);
        exp_at(5, "rst_after", 2'd0, 0, 0, 0, 6'd0, 2'd0, 8'd0);
        step();
        start = 1'b0; submit = 1'b1; sel = 2'd0;
        step(); sel = 2'd1;
        step(); submit = 1'b0; reset = 1'b1;
        step(); reset = 1'b0;
        step();

        // 256 wins from reset: score saturates at 255.
        exp_score = 0;
        for (int i = 0; i < 256; i++) quick_win("sat_win");
        step(); step();

        for (int i = 0; i < 50 && sb.size() > 0; i++) step();
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations never sampled", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
